// File: rtl/cla_seq_multiplier.sv
// cla_seq_multiplier: 32x32->64 unsigned shift-add multiplier built around one Cla_32 adder.
// Optional early termination when the remaining multiplier bits are zero: define CLA_MUL_EARLY_TERM_EN.
module Cla_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c32,
  output logic        G,
  output logic        P
);
  logic [31:0] w_g, w_p, w_c;
  logic [7:0]  w_gg, w_gp;
  logic [8:0]  w_cg;
  assign w_g     = x & y;
  assign w_p     = x ^ y;
  assign w_cg[0] = c_in;
  for (genvar k = 0; k < 8; k++) begin : g_blk
    localparam int B = 4 * k;
    assign w_c[B]   = w_cg[k];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_cg[k]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (&w_p[B+1:B] & w_cg[k]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (&w_p[B+2:B+1] & w_g[B])
                    | (&w_p[B+2:B] & w_cg[k]);
    assign w_gg[k]  = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (&w_p[B+3:B+2] & w_g[B+1])
                    | (&w_p[B+3:B+1] & w_g[B]);
    assign w_gp[k]  = &w_p[B+3:B];
    assign w_cg[k+1] = w_gg[k] | (w_gp[k] & w_cg[k]);
  end
  assign sum = w_p ^ w_c;
  assign c32 = w_cg[8];
  assign P   = &w_gp;
  always_comb begin
    G = 1'b0;
    for (int i = 0; i < 8; i++) G = w_gg[i] | (w_gp[i] & G);
  end
endmodule

module cla_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  if (WIDTH != 32) begin : g_bad_width
    $error("cla_seq_multiplier: WIDTH must be 32 (fixed by Cla_32)");
  end
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_m, r_acc, r_q, r_mr;
  logic [5:0]  r_cnt;
  logic        r_valid;
  logic [31:0] w_sum;
  logic        w_c32, w_accept, w_last;
  Cla_32 u_cla (
    .x    (r_acc),
    .y    (r_mr[0] ? r_m : 32'd0),
    .c_in (1'b0),
    .sum  (w_sum),
    .c32  (w_c32),
    .G    (),
    .P    ()
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_accept = start && (r_state != S_BUSY);
`ifdef CLA_MUL_EARLY_TERM_EN
    w_last   = (r_mr == 32'd0) || (r_cnt == 6'd31);
`else
    w_last   = (r_cnt == 6'd31);
`endif
    w_next   = (r_state == S_BUSY) ? (w_last ? S_DONE : S_BUSY)
                                   : (w_accept ? S_BUSY : S_IDLE);
  end
  always_comb begin
    busy    = (r_state == S_BUSY);
    done    = (r_state == S_DONE);
    product = r_valid ? {r_acc, r_q} : 64'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_m, r_acc, r_q, r_mr} <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_m     <= a;
      r_mr    <= b;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_valid <= w_last;
`ifdef CLA_MUL_EARLY_TERM_EN
      if (r_mr == 32'd0) begin
        // remaining iterations would only add zero and shift, so collapse them
        {r_acc, r_q} <= {r_acc, r_q} >> (6'd32 - r_cnt);
      end else
`endif
      begin
        {r_acc, r_q} <= {w_c32, w_sum, r_q[31:1]};
        r_mr         <= r_mr >> 1;
        r_cnt        <= r_cnt + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_cla_seq_multiplier.sv
// tb_cla_seq_multiplier: directed and random checks against plain 64-bit multiplication.
module tb_cla_seq_multiplier;
  logic        clk = 0, rst = 1, start = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done;
  logic [63:0] product;
  int          n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;

  cla_seq_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [31:0] bv);
`ifdef CLA_MUL_EARLY_TERM_EN
    if (bv == 0) return 1;
    for (int i = 31; i >= 0; i--) if (bv[i]) return (i + 2 > 32) ? 32 : i + 2;
`endif
    return 32;
  endfunction

  task automatic launch(input logic [31:0] av, input logic [31:0] bv);
    a = av; b = bv; start = 1;
    tick;
    t0 = cyc;
    start = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int lat, input logic [63:0] exp);
    while (!done && cyc - t0 < 40) tick;
    chk({tag, "_lat"}, 64'(cyc - t0), 64'(lat));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_prod"}, product, exp);
  endtask

  task automatic after_done(input string tag, input logic [63:0] exp);
    tick;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, product, exp);
  endtask

  task automatic op(input string tag, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] exp;
    exp = 64'(av) * 64'(bv);
    launch(av, bv);
    wait_done(tag, exp_lat(bv), exp);
    after_done(tag, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        seen;
    tick; tick;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", product, 64'd0);
    rst = 0;
    tick;
    chk("idle_prod", product, 64'd0);

    op("one_x_ffff", 32'h1, 32'hFFFFFFFF);
    chk("one_x_ffff_val", product, 64'h00000000FFFFFFFF);
    op("max_x_max", 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("max_x_max_val", product, 64'hFFFFFFFE00000001);
    op("b_zero", 32'h12345678, 32'h0);

    // start during BUSY is ignored; start held in DONE re-enters BUSY at once
    launch(32'd3, 32'd5);
    repeat (9) tick;
    a = 7; b = 9; start = 1;
    tick;
    start = 0;
    chk("ign_busy", 64'(busy), 64'd1);
    wait_done("ign", exp_lat(32'd5), 64'd15);
    a = 7; b = 9; start = 1;
    tick;
    t0 = cyc;
    start = 0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_done", 64'(done), 64'd0);
    wait_done("b2b", exp_lat(32'd9), 64'd63);
    after_done("b2b", 64'd63);

    // reset mid-operation aborts without a done pulse
    launch(32'hFFFF, 32'hFFFF);
    repeat (15) tick;
    rst = 1;
    tick;
    rst = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", product, 64'd0);
    seen = 0;
    repeat (40) begin tick; seen |= done; end
    chk("abort_no_done", 64'(seen), 64'd0);
    op("after_abort", 32'd2, 32'd3);

    // rst and start together: rst wins
    a = 5; b = 5; start = 1; rst = 1;
    tick;
    start = 0; rst = 0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    chk("rst_start_prod", product, 64'd0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 6 == 0) rb = 0;
      op("rand", ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
